// File: rtl/countdown_timer_bcd.sv
// HH:MM:SS BCD countdown timer with load/start/pause control and a one-cycle expiry pulse.
// Define TIMER_AUTO_RELOAD_EN to add the autoReload input and the reload register.
module countdown_timer_bcd #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DIV_W      = 26,
  parameter int unsigned MAX_HOUR10 = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
`ifdef TIMER_AUTO_RELOAD_EN
  input  logic       autoReload,
`endif
  input  logic [3:0] setHour10,
  input  logic [3:0] setHour1,
  input  logic [3:0] setMinute10,
  input  logic [3:0] setMinute1,
  input  logic [3:0] setSecond10,
  input  logic [3:0] setSecond1,
  output logic [3:0] getHour10,
  output logic [3:0] getHour1,
  output logic [3:0] getMinute10,
  output logic [3:0] getMinute1,
  output logic [3:0] getSecond10,
  output logic [3:0] getSecond1,
  output logic       running,
  output logic       isZero,
  output logic       complete
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]       H10_MAX   = 4'(MAX_HOUR10);

  state_t            state_q, state_d;
  logic [23:0]       count_q, count_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic              complete_q, complete_d;
  logic              running_q, running_d;
  logic              is_zero_q, is_zero_d;
  logic [23:0]       set_clamped;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [23:0]       reload_q, reload_d;
`endif

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // Digit order in the packed count, LSB first: s1, s10, m1, m10, h1, h10.
  function automatic logic [23:0] bcd_dec(input logic [23:0] c);
    logic [23:0] r;
    logic        borrow;
    logic [3:0]  mx;
    r = c;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mx = (i == 1 || i == 3) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (c[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = mx;
        end else begin
          r[i*4 +: 4] = c[i*4 +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign set_clamped = {clamp(setHour10, H10_MAX), clamp(setHour1, 4'd9),
                        clamp(setMinute10, 4'd5),  clamp(setMinute1, 4'd9),
                        clamp(setSecond10, 4'd5),  clamp(setSecond1, 4'd9)};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    complete_d = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    reload_d   = reload_q;
`endif
    if (load) begin
      count_d = set_clamped;
      presc_d = '0;
      state_d = IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_d = set_clamped;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start && !pause) begin
            if (count_q != 24'd0) begin
              state_d = RUN;
              presc_d = '0;
            end else if (state_q == IDLE) begin
              state_d    = DONE;
              complete_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (presc_q == TICK_LAST) begin
            presc_d = '0;
            count_d = bcd_dec(count_q);
            if (count_d == 24'd0) begin
              complete_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
              if (autoReload && reload_q != 24'd0) count_d = reload_q;
              else state_d = DONE;
`else
              state_d = DONE;
`endif
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSE: begin
          if (start && !pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    is_zero_d = (count_d == 24'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      presc_q    <= '0;
      complete_q <= 1'b0;
      running_q  <= 1'b0;
      is_zero_q  <= 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      complete_q <= complete_d;
      running_q  <= running_d;
      is_zero_q  <= is_zero_d;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_q   <= reload_d;
`endif
    end
  end

  assign {getHour10, getHour1, getMinute10, getMinute1, getSecond10, getSecond1} = count_q;
  assign running  = running_q;
  assign isZero   = is_zero_q;
  assign complete = complete_q;

endmodule
